// File: rtl/aclk_controller_if.sv
// aclk_controller_if: keypad inputs and display/load outputs of the alarm clock sequencer
interface aclk_controller_if;
  logic [3:0] key;
  logic       one_second;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic       show_new_time, show_a, load_new_c, load_new_a;
  modport master (
    output key, one_second,
    input  key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
    input  show_new_time, show_a, load_new_c, load_new_a
  );
  modport slave (
    input  key, one_second,
    output key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
    output show_new_time, show_a, load_new_c, load_new_a
  );
endinterface

// File: rtl/aclk_controller.sv
// aclk_controller: keypad entry sequencer with key buffer, load strobes and entry timeout
module aclk_controller #(
  parameter int TIMEOUT_S = 10
) (
  input logic               clock,
  input logic               reset_n,
  aclk_controller_if.slave  bus
);
  typedef enum logic [2:0] {SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM} state_t;
  state_t state, state_nxt;
  logic [3:0] key_prev, digit, cnt;
  logic press, is_digit, tick, timeout, valid, load_c, load_a, clear;
  always_comb begin
    press = bus.key != 4'd15 && key_prev == 4'd15;
    is_digit = bus.key <= 4'd9;
    tick = bus.one_second && (state == KEY_WAITED || state == KEY_ENTRY);
    timeout = tick && cnt == 4'(TIMEOUT_S - 1);
    valid = bus.key_ms_hr <= 4'd2 && (bus.key_ms_hr < 4'd2 || bus.key_ls_hr <= 4'd3) && bus.key_ms_min <= 4'd5;
    state_nxt = state;
    load_c = 1'b0;
    load_a = 1'b0;
    clear = 1'b0;
    case (state)
      SHOW_TIME:
        if (press && is_digit) begin
          state_nxt = KEY_STORED;
          clear = 1'b1;
        end else if (press && bus.key == 4'd10) state_nxt = SHOW_ALARM;
      KEY_STORED: state_nxt = KEY_WAITED;
      KEY_WAITED:
        if (bus.key == 4'd15) state_nxt = KEY_ENTRY;
        else if (timeout) state_nxt = SHOW_TIME;
      KEY_ENTRY:
        if (press && is_digit) state_nxt = KEY_STORED;
        else if (press && bus.key == 4'd11) begin
          state_nxt = SHOW_TIME;
          load_c = valid;
        end else if (press && bus.key == 4'd10) begin
          state_nxt = SHOW_TIME;
          load_a = valid;
        end else if (timeout) state_nxt = SHOW_TIME;
      SHOW_ALARM: state_nxt = bus.key == 4'd15 ? SHOW_TIME : SHOW_ALARM;
      default: state_nxt = SHOW_TIME;
    endcase
  end
  // The buffer shifts on the edge leaving KEY_STORED, using the digit latched at the press.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= SHOW_TIME;
      key_prev <= 4'd15;
      digit <= 4'd0;
      cnt <= 4'd0;
      {bus.key_ms_hr, bus.key_ls_hr, bus.key_ms_min, bus.key_ls_min} <= 16'd0;
      bus.show_new_time <= 1'b0;
      bus.show_a <= 1'b0;
      bus.load_new_c <= 1'b0;
      bus.load_new_a <= 1'b0;
    end else begin
      state <= state_nxt;
      key_prev <= bus.key;
      if (state_nxt == KEY_STORED) digit <= bus.key;
      cnt <= state_nxt == KEY_STORED ? 4'd0 : tick ? cnt + 4'd1 : cnt;
      if (clear) {bus.key_ms_hr, bus.key_ls_hr, bus.key_ms_min, bus.key_ls_min} <= 16'd0;
      else if (state == KEY_STORED)
        {bus.key_ms_hr, bus.key_ls_hr, bus.key_ms_min, bus.key_ls_min} <= {bus.key_ls_hr, bus.key_ms_min, bus.key_ls_min, digit};
      bus.show_new_time <= state_nxt inside {KEY_STORED, KEY_WAITED, KEY_ENTRY};
      bus.show_a <= state_nxt == SHOW_ALARM;
      bus.load_new_c <= load_c;
      bus.load_new_a <= load_a;
    end
  end
endmodule
